// File: rtl/eci_chan_buf.sv
// Multi-channel ECI packet buffer: one DEPTH-entry FIFO per channel with a fill
// level, optionally merged onto output lane 0 through a locking round-robin arbiter.
module eci_chan_buf #(
    parameter int NUM_CHAN   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SIZE_WIDTH = 5,
    parameter int VC_WIDTH   = 4,
    parameter int DEPTH      = 4,
    parameter int MERGE      = 0,
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CHAN*SIZE_WIDTH-1:0] s_size,
    input  logic [NUM_CHAN*VC_WIDTH-1:0]   s_vc,
    input  logic [NUM_CHAN-1:0]            s_valid,
    output logic [NUM_CHAN-1:0]            s_ready,
    output logic [NUM_CHAN*DATA_WIDTH-1:0] m_data,
    output logic [NUM_CHAN*SIZE_WIDTH-1:0] m_size,
    output logic [NUM_CHAN*VC_WIDTH-1:0]   m_vc,
    output logic [NUM_CHAN-1:0]            m_valid,
    input  logic [NUM_CHAN-1:0]            m_ready,
    output logic [CW-1:0]                  m_chan,
    output logic [NUM_CHAN*LW-1:0]         fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + SIZE_WIDTH + VC_WIDTH;

    logic                        rst_done;
    logic [NUM_CHAN-1:0]         req;
    logic [NUM_CHAN-1:0]         push;
    logic [NUM_CHAN-1:0]         pop;
    logic [NUM_CHAN-1:0][EW-1:0] head;
    logic                        any_req;
    logic [CW-1:0]               grant;

    // Holds s_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    assign any_req = |req;

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        logic [EW-1:0] mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [LW-1:0] count;

        // Ready depends only on registered occupancy, so a full FIFO refuses a beat
        // even in the cycle it is being popped.
        assign s_ready[g]        = rst_done && (count != LW'(DEPTH));
        assign push[g]           = s_valid[g] && s_ready[g];
        assign req[g]            = (count != '0);
        assign head[g]           = mem[rd_ptr];
        assign fill[g*LW +: LW]  = count;

        if (MERGE != 0) begin : g_pop_merge
            assign pop[g] = any_req && m_ready[0] && (grant == CW'(g));
        end else begin : g_pop_lane
            assign pop[g] = req[g] && m_ready[g];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   count <= count + LW'(1);
                    2'b01:   count <= count - LW'(1);
                    default: count <= count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem[wr_ptr] <= {s_data[g*DATA_WIDTH +: DATA_WIDTH],
                                s_size[g*SIZE_WIDTH +: SIZE_WIDTH],
                                s_vc[g*VC_WIDTH +: VC_WIDTH]};
            end
        end
    end

    if (MERGE != 0) begin : g_arb
        logic [CW-1:0] rr_ptr;
        logic [CW-1:0] lock_chan;
        logic [CW-1:0] search;
        logic [CW-1:0] next_ptr;
        logic          locked;
        logic          found;
        logic          unused_ready;

        assign unused_ready = ^m_ready;

        always_comb begin
            int idx;
            search = '0;
            found  = 1'b0;
            idx    = 0;
            for (int off = 0; off < NUM_CHAN; off++) begin
                idx = (int'(rr_ptr) + off) % NUM_CHAN;
                if (!found && req[idx]) begin
                    search = CW'(idx);
                    found  = 1'b1;
                end
            end
        end

        // A stalled beat keeps its grant so the lane-0 payload cannot change under it.
        assign grant    = locked ? lock_chan : search;
        assign next_ptr = (grant == CW'(NUM_CHAN - 1)) ? '0 : grant + CW'(1);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rr_ptr    <= '0;
                locked    <= 1'b0;
                lock_chan <= '0;
            end else begin
                lock_chan <= grant;
                if (any_req && m_ready[0]) begin
                    rr_ptr <= next_ptr;
                    locked <= 1'b0;
                end else begin
                    locked <= any_req;
                end
            end
        end
    end else begin : g_no_arb
        assign grant = '0;
    end

    // Empty lanes are masked to zero because FIFO storage is never reset.
    always_comb begin
        m_data  = '0;
        m_size  = '0;
        m_vc    = '0;
        m_valid = '0;
        m_chan  = '0;
        if (MERGE != 0) begin
            m_valid[0] = any_req;
            if (any_req) begin
                {m_data[0 +: DATA_WIDTH], m_size[0 +: SIZE_WIDTH], m_vc[0 +: VC_WIDTH]} = head[grant];
                m_chan = grant;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                m_valid[i] = req[i];
                if (req[i]) begin
                    {m_data[i*DATA_WIDTH +: DATA_WIDTH],
                     m_size[i*SIZE_WIDTH +: SIZE_WIDTH],
                     m_vc[i*VC_WIDTH +: VC_WIDTH]} = head[i];
                end
            end
        end
    end

endmodule
